// File: rtl/flatten_streamer.sv
// Reads an HWC-interleaved feature map and streams it to the FC stage in CHW order, one sample per cycle.
// The FC stage is held until sample 0 reaches dout; the frame completes once the FC reports done.
module flatten_streamer #(
  parameter int DW = 9,
  parameter int CH = 8,
  parameter int HT = 14,
  parameter int WD = 14,
  parameter int AW = 11
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 buf_en,
  output logic [AW-1:0]        buf_addr,
  input  logic signed [DW-1:0] buf_data,
  output logic signed [DW-1:0] dout,
  output logic                 dout_valid,
  output logic                 fc_hold,
  input  logic                 fc_done,
  output logic                 busy,
  output logic                 done
);

  localparam int CCW = (WD > 1) ? $clog2(WD) : 1;
  localparam int RCW = (HT > 1) ? $clog2(HT) : 1;
  localparam int HCW = (CH > 1) ? $clog2(CH) : 1;

  localparam logic [CCW-1:0] C_LAST  = CCW'(WD - 1);
  localparam logic [RCW-1:0] R_LAST  = RCW'(HT - 1);
  localparam logic [HCW-1:0] CH_LAST = HCW'(CH - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    TAIL  = 3'd2,
    WAIT  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t         state, state_n;
  logic [CCW-1:0] c_q, c_n;
  logic [RCW-1:0] r_q, r_n;
  logic [HCW-1:0] ch_q, ch_n;
  logic [AW-1:0]  addr_n;
  logic           last_k;
  logic           rd_pend;

  // Frame end comes from the loop counters, not from the address value.
  assign last_k = (ch_q == CH_LAST) && (r_q == R_LAST) && (c_q == C_LAST);

  assign addr_n = (AW'(r_n) * AW'(WD) + AW'(c_n)) * AW'(CH) + AW'(ch_n);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      c_q   <= '0;
      r_q   <= '0;
      ch_q  <= '0;
    end else begin
      state <= state_n;
      c_q   <= c_n;
      r_q   <= r_n;
      ch_q  <= ch_n;
    end
  end

  always_comb begin
    state_n = state;
    c_n     = c_q;
    r_n     = r_q;
    ch_n    = ch_q;
    case (state)
      IDLE: begin
        if (start) state_n = ISSUE;
      end
      ISSUE: begin
        if (last_k) begin
          state_n = TAIL;
          c_n     = '0;
          r_n     = '0;
          ch_n    = '0;
        end else if (c_q == C_LAST) begin
          c_n = '0;
          if (r_q == R_LAST) begin
            r_n  = '0;
            ch_n = ch_q + 1'b1;
          end else begin
            r_n = r_q + 1'b1;
          end
        end else begin
          c_n = c_q + 1'b1;
        end
      end
      TAIL:    state_n = WAIT;
      WAIT: begin
        if (fc_done) state_n = DONE;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_en     <= 1'b0;
      buf_addr   <= '0;
      rd_pend    <= 1'b0;
      dout       <= '0;
      dout_valid <= 1'b0;
      fc_hold    <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      buf_en     <= (state_n == ISSUE);
      buf_addr   <= (state_n == ISSUE) ? addr_n : '0;
      rd_pend    <= buf_en;
      dout_valid <= rd_pend;
      dout       <= rd_pend ? buf_data : '0;
      busy       <= (state_n != IDLE);
      done       <= (state_n == DONE);
      // FC is released exactly when sample 0 lands on dout.
      if (state_n == DONE)
        fc_hold <= 1'b1;
      else if (rd_pend)
        fc_hold <= 1'b0;
    end
  end

endmodule

// File: tb/tb_flatten_streamer.sv
// Scoreboard bench for flatten_streamer: stimulus pushes expected addresses/samples,
// a negedge monitor pops and compares whenever the DUT drives buf_en or dout_valid.
module tb_flatten_streamer;

  localparam int DW = 9;
  localparam int CH = 8;
  localparam int HT = 14;
  localparam int WD = 14;
  localparam int AW = 11;
  localparam int N  = CH * HT * WD;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          fc_done = 1'b0;
  logic          buf_en;
  logic [AW-1:0] buf_addr;
  logic [DW-1:0] buf_data = '0;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic          fc_hold;
  logic          busy;
  logic          done;

  logic          mem_mode = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [AW-1:0] addr_q[$];
  logic [DW-1:0] data_q[$];
  logic [AW-1:0] addr_log[N];
  int            issue_idx = 0;
  int            vcount = 0;
  int            done_cnt = 0;
  logic [AW-1:0] ea;
  logic [DW-1:0] ed;

  flatten_streamer #(.DW(DW), .CH(CH), .HT(HT), .WD(WD), .AW(AW)) dut (
    .clk(clk), .rst(rst), .start(start),
    .buf_en(buf_en), .buf_addr(buf_addr), .buf_data(buf_data),
    .dout(dout), .dout_valid(dout_valid), .fc_hold(fc_hold),
    .fc_done(fc_done), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] mem_val(input logic [AW-1:0] a, input logic m);
    logic [DW-1:0] v;
    v = m ? 9'h100 : a[DW-1:0];
    return v;
  endfunction

  // Synchronous buffer: data for an address appears one edge after it is presented.
  always @(posedge clk) if (buf_en) buf_data <= mem_val(buf_addr, mem_mode);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=unexpected required=none at %0t", name, $time);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (buf_en) begin
        if (addr_q.size() == 0) fail_now("addr_q_empty");
        else begin
          ea = addr_q.pop_front();
          chk("buf_addr", 32'(buf_addr), 32'(ea));
        end
        if (issue_idx < N) addr_log[issue_idx] = buf_addr;
        issue_idx++;
      end
      if (dout_valid) begin
        vcount++;
        if (data_q.size() == 0) fail_now("data_q_empty");
        else begin
          ed = data_q.pop_front();
          chk("dout", 32'(dout), 32'(ed));
        end
      end else begin
        chk("dout_idle_zero", 32'(dout), 0);
      end
      if (done) done_cnt++;
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic push_frame(input logic m);
    int a;
    for (int ch = 0; ch < CH; ch++)
      for (int r = 0; r < HT; r++)
        for (int c = 0; c < WD; c++) begin
          a = (r * WD + c) * CH + ch;
          addr_q.push_back(AW'(a));
          data_q.push_back(mem_val(AW'(a), m));
        end
  endtask

  task automatic run_frame(input logic m, input logic late_fc, input logic restart_mid);
    int d0;
    mem_mode  = m;
    push_frame(m);
    issue_idx = 0;
    vcount    = 0;
    d0        = done_cnt;
    fc_done   = !late_fc;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("c0_buf_en", 32'(buf_en), 1);
    chk("c0_addr", 32'(buf_addr), 0);
    chk("c0_busy", 32'(busy), 1);
    chk("c0_dvalid", 32'(dout_valid), 0);
    chk("c0_hold", 32'(fc_hold), 1);
    step();
    chk("c1_dvalid", 32'(dout_valid), 0);
    chk("c1_hold", 32'(fc_hold), 1);
    for (int cyc = 2; cyc <= N + 1; cyc++) begin
      step();
      if (cyc == 2) begin
        chk("c2_dvalid", 32'(dout_valid), 1);
        chk("c2_hold", 32'(fc_hold), 0);
      end
      if (late_fc && cyc == 100) fc_done = 1'b1;
      if (late_fc && cyc == 110) fc_done = 1'b0;
      if (restart_mid && cyc == 502) start = 1'b1;
      if (restart_mid && cyc == 503) start = 1'b0;
      if (cyc == N + 1) begin
        chk("last_dvalid", 32'(dout_valid), 1);
        chk("last_hold", 32'(fc_hold), 0);
        chk("last_buf_en", 32'(buf_en), 0);
        chk("last_done", 32'(done), 0);
      end
    end
    step();
    chk("post_dvalid", 32'(dout_valid), 0);
    if (!late_fc) begin
      chk("done_pulse", 32'(done), 1);
      chk("done_hold", 32'(fc_hold), 1);
      fc_done = 1'b0;
    end else begin
      chk("wait_no_done", 32'(done), 0);
      chk("wait_busy", 32'(busy), 1);
      chk("wait_hold", 32'(fc_hold), 0);
      repeat (4) step();
      chk("wait_late_no_done", 32'(done), 0);
      fc_done = 1'b1;
      step();
      chk("late_done_pulse", 32'(done), 1);
      chk("late_done_hold", 32'(fc_hold), 1);
      chk("late_done_busy", 32'(busy), 1);
      fc_done = 1'b0;
    end
    step();
    chk("end_done_low", 32'(done), 0);
    chk("end_busy_low", 32'(busy), 0);
    chk("end_hold", 32'(fc_hold), 1);
    chk("valid_count", 32'(vcount), 32'(N));
    chk("done_count", 32'(done_cnt - d0), 1);
    chk("addr_q_left", 32'(addr_q.size()), 0);
    chk("data_q_left", 32'(data_q.size()), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    step();
    step();
    chk("rst_hold", 32'(fc_hold), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_buf_en", 32'(buf_en), 0);
    chk("rst_addr", 32'(buf_addr), 0);
    chk("rst_dvalid", 32'(dout_valid), 0);
    chk("rst_done", 32'(done), 0);
    rst = 1'b1;
    step();

    // Frame with fc_done held high throughout: early level must be ignored.
    run_frame(1'b0, 1'b0, 1'b0);
    chk("addr_k1", 32'(addr_log[1]), 8);
    chk("addr_k13", 32'(addr_log[13]), 104);
    chk("addr_k14", 32'(addr_log[14]), 112);
    chk("addr_k195", 32'(addr_log[195]), 1560);
    chk("addr_k196", 32'(addr_log[196]), 1);
    chk("addr_k1567", 32'(addr_log[1567]), 1567);

    // Late fc_done with an ignored mid-frame start, then a start one cycle after done.
    run_frame(1'b0, 1'b1, 1'b1);
    run_frame(1'b1, 1'b0, 1'b0);

    // Asynchronous abort at sample 700.
    mem_mode = 1'b0;
    push_frame(1'b0);
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (702) step();
    chk("pre_rst_dvalid", 32'(dout_valid), 1);
    #2 rst = 1'b0;
    #1;
    chk("abort_hold", 32'(fc_hold), 1);
    chk("abort_dvalid", 32'(dout_valid), 0);
    chk("abort_buf_en", 32'(buf_en), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_dout", 32'(dout), 0);
    chk("abort_addr", 32'(buf_addr), 0);
    addr_q.delete();
    data_q.delete();
    step();
    step();
    rst = 1'b1;
    step();
    chk("post_rst_busy", 32'(busy), 0);
    chk("post_rst_buf_en", 32'(buf_en), 0);
    run_frame(1'b0, 1'b0, 1'b0);
    chk("rst_frame_addr_k1", 32'(addr_log[1]), 8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
